// File: rtl/round_ctrl.sv
// Feistel round sequencer: loads a block, drives R to the external f-function,
// applies ROUNDS rounds and emits the swapped result with a one-cycle done pulse.
// Optional macro ROUND_CTRL_STALL_EN adds f_valid_i to stall rounds.
module round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] data_in_i,
  input  logic [63:0]  f_in_i,
`ifdef ROUND_CTRL_STALL_EN
  input  logic         f_valid_i,
`endif
  output logic [63:0]  r_out_o,
  output logic [3:0]   round_idx_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] data_out_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [63:0]  l_q, l_d;
  logic [63:0]  r_q, r_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] dout_q, dout_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         adv_s;
  logic [63:0]  new_r_s;

`ifdef ROUND_CTRL_STALL_EN
  assign adv_s = f_valid_i;
`else
  assign adv_s = 1'b1;
`endif

  assign new_r_s = l_q ^ f_in_i;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          l_d     = data_in_i[127:64];
          r_d     = data_in_i[63:0];
          idx_d   = 4'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (adv_s) begin
          l_d = r_q;
          r_d = new_r_s;
          if (idx_q == LAST_IDX) begin
            // final swap: {new R, new L}
            dout_d  = {new_r_s, r_q};
            idx_d   = 4'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // done pulse is registered, so it appears as the FSM returns to IDLE
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      l_q     <= 64'd0;
      r_q     <= 64'd0;
      idx_q   <= 4'd0;
      dout_q  <= 128'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign r_out_o     = r_q;
  assign round_idx_o = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign data_out_o  = dout_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: a 16-round and a 1-round instance, with a
// bench-side Feistel model producing every expected DATA_OUT.
module tb_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_a, start_b, f_valid;
  logic [127:0] din_a, din_b;
  logic [63:0]  f_in_a, f_in_b, r_out_a, r_out_b;
  logic [3:0]   idx_a, idx_b;
  logic         busy_a, busy_b, done_a, done_b;
  logic [127:0] data_out_a, data_out_b;
  logic         fmode;
  logic [63:0]  fconst;

  int total = 0;
  int bad   = 0;
  logic [127:0] qa[$];
  logic [127:0] qb[$];
  logic [127:0] prev_a, prev_b, e_a, e_b;
  int dones_a = 0;
  int dones_b = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] tb_f(input logic [63:0] r, input logic [3:0] idx);
    return {r[40:0], r[63:41]} ^ {60'd0, idx} ^ 64'h9E3779B97F4A7C15;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input int rounds,
                                         input logic fm, input logic [63:0] fc);
    logic [63:0] l, r, f, t;
    l = d[127:64];
    r = d[63:0];
    for (int i = 0; i < rounds; i++) begin
      f = fm ? tb_f(r, 4'(i)) : fc;
      t = r;
      r = l ^ f;
      l = t;
    end
    return {r, l};
  endfunction

  assign f_in_a = fmode ? tb_f(r_out_a, idx_a) : fconst;
  assign f_in_b = fmode ? tb_f(r_out_b, idx_b) : fconst;

  round_ctrl #(.ROUNDS(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .data_in_i(din_a), .f_in_i(f_in_a),
`ifdef ROUND_CTRL_STALL_EN
    .f_valid_i(f_valid),
`endif
    .r_out_o(r_out_a), .round_idx_o(idx_a), .busy_o(busy_a), .done_o(done_a),
    .data_out_o(data_out_a)
  );

  round_ctrl #(.ROUNDS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .data_in_i(din_b), .f_in_i(f_in_b),
`ifdef ROUND_CTRL_STALL_EN
    .f_valid_i(f_valid),
`endif
    .r_out_o(r_out_b), .round_idx_o(idx_b), .busy_o(busy_b), .done_o(done_b),
    .data_out_o(data_out_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: each done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      dones_a++;
      check("sb_a_pending", 128'(qa.size() > 0), 128'd1);
      if (qa.size() > 0) begin
        e_a = qa.pop_front();
        check("dout_a", data_out_a, e_a);
      end
    end
    if (done_b === 1'b1) begin
      dones_b++;
      check("sb_b_pending", 128'(qb.size() > 0), 128'd1);
      if (qb.size() > 0) begin
        e_b = qb.pop_front();
        check("dout_b", data_out_b, e_b);
      end
    end
  end

  task automatic run_block(input bit sel, input logic [127:0] d,
                           input int stall_at, input int stall_len);
    int rounds, rd, lat;
    bit fv, got;
    logic [127:0] e, pv;
    rounds = sel ? 1 : 16;
    e  = model(d, rounds, fmode, fconst);
    pv = sel ? prev_b : prev_a;
    @(negedge clk);
    if (sel) begin din_b = d; start_b = 1'b1; qb.push_back(e); end
    else     begin din_a = d; start_a = 1'b1; qa.push_back(e); end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    check("idx_load", 128'(sel ? idx_b : idx_a), 128'd0);
    check("busy_run", 128'(sel ? busy_b : busy_a), 128'd1);
    rd = 0; got = 1'b0; lat = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      fv = f_valid;
      @(posedge clk); #1;
      if (fv && rd < rounds) rd++;
      if (n == stall_at) f_valid = 1'b0;
      if (n == stall_at + stall_len) f_valid = 1'b1;
      if ((sel ? done_b : done_a) === 1'b1) begin
        got = 1'b1;
        lat = n;
      end else begin
        check("idx_step", 128'(sel ? idx_b : idx_a), 128'((rd < rounds) ? rd : 0));
        check("busy_hold", 128'(sel ? busy_b : busy_a), 128'd1);
        check("dout_hold", sel ? data_out_b : data_out_a, (rd == rounds) ? e : pv);
      end
    end
    f_valid = 1'b1;
    check("done_seen", 128'(got), 128'd1);
    check("latency", 128'(lat), 128'(rounds + 1 + stall_len));
    if (sel) prev_b = e; else prev_a = e;
    @(posedge clk); #1;
    check("done_1cyc", 128'(sel ? done_b : done_a), 128'd0);
    check("busy_idle", 128'(sel ? busy_b : busy_a), 128'd0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] d;
    int c, first, second, base;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; f_valid = 1'b1;
    din_a = 128'd0; din_b = 128'd0; fmode = 1'b0; fconst = 64'd0;
    prev_a = 128'd0; prev_b = 128'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_out", 128'(r_out_a), 128'd0);
    check("rst_dout", data_out_a, 128'd0);
    check("rst_busy", 128'(busy_a), 128'd0);
    check("rst_done", 128'(done_a), 128'd0);
    check("rst_idx", 128'(idx_a), 128'd0);
    check("rst_dout_b", data_out_b, 128'd0);
    @(negedge clk); rst = 1'b0;

    // zero f-function: 16 rounds reduce to a pure half swap
    run_block(1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 0);
    check("swap16", data_out_a, 128'hFEDCBA9876543210_0123456789ABCDEF);

    fconst = 64'hFF;
    run_block(1'b1, {64'h1, 64'h2}, 0, 0);
    check("one_round", data_out_b, {64'hFE, 64'h2});

    // data-dependent f: back-to-back blocks on both instances
    fmode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_block(1'b0, rnd128(), 0, 0);
      run_block(1'b1, rnd128(), 0, 0);
    end

    // START held high: one block per IDLE visit
    d = rnd128();
    e_a = model(d, 16, fmode, fconst);
    @(negedge clk);
    din_a = d; start_a = 1'b1;
    qa.push_back(e_a); qa.push_back(e_a);
    c = 0; first = -1; second = -1;
    while (c < 80 && second < 0) begin
      @(posedge clk); #1;
      c++;
      if (done_a === 1'b1) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    start_a = 1'b0;
    check("held_first", 128'(first), 128'd18);
    check("held_second", 128'(second), 128'd36);
    prev_a = e_a;
    repeat (20) @(posedge clk);
    #1;
    check("held_no_third", 128'(busy_a), 128'd0);

`ifdef ROUND_CTRL_STALL_EN
    run_block(1'b0, rnd128(), 5, 3);
`endif

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    din_a = rnd128(); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", 128'(busy_a), 128'd0);
    check("abort_r_out", 128'(r_out_a), 128'd0);
    check("abort_dout", data_out_a, 128'd0);
    check("abort_idx", 128'(idx_a), 128'd0);
    @(negedge clk); rst = 1'b0;
    base = dones_a;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 128'(dones_a), 128'(base));
    check("sb_a_drained", 128'(qa.size()), 128'd0);
    check("sb_b_drained", 128'(qb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
